// File: rtl/mem_read_sequencer_pkg.sv
// mem_read_sequencer_pkg: FSM encoding and default widths shared with the ROM and display modules.
package mem_read_sequencer_pkg;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer: steps a ROM read pointer on each enable strobe and holds the fetched word for display.
module mem_read_sequencer
  import mem_read_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = 128,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, addr_q;
  logic [1:0] cnt;
  logic pending, fire;
  assign fire     = state == S_IDLE && (enable || pending) && !restart;
  assign rom_rd   = fire;
  assign rom_addr = fire ? ptr : addr_q;
  assign busy     = state != S_IDLE;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = fire ? (ROM_LATENCY == 1 ? S_CAPTURE : S_WAIT) : S_IDLE;
      S_WAIT:  state_n = cnt == 2'd1 ? S_CAPTURE : S_WAIT;
      default: state_n = S_IDLE;
    endcase
    if (restart) state_n = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      addr_q     <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      data_out   <= '0;
      addr_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      data_valid <= 1'b0;
      if (restart) begin
        ptr     <= '0;
        pending <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (fire) begin
          addr_q <= ptr;
          cnt    <= 2'(ROM_LATENCY - 1);
        end
        if (state == S_WAIT) cnt <= cnt - 2'd1;
        // A strobe landing on a pending fetch can only be merged once; the next is lost.
        if (state == S_IDLE) begin
          pending <= 1'b0;
          if (enable && pending) overrun <= 1'b1;
        end else if (enable) begin
          if (pending) overrun <= 1'b1;
          else pending <= 1'b1;
        end
        if (state == S_CAPTURE) begin
          data_out   <= rom_data;
          addr_out   <= ptr;
          data_valid <= 1'b1;
          ptr        <= ptr == ADDR_WIDTH'(DEPTH - 1) ? '0 : ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_read_sequencer.sv
// tb_mem_read_sequencer: drives latency-1 and latency-2 instances in lockstep against scoreboards of expected captures.
module tb_mem_read_sequencer;
  logic clk = 0, rst_n, enable, restart;
  logic [6:0] rom_addr0, rom_addr1, addr_out0, addr_out1;
  logic [31:0] rom_data0, rom_data1, data_out0, data_out1, r1a;
  logic rom_rd0, rom_rd1, dv0, dv1, busy0, busy1, ov0, ov1;
  int n_chk = 0, n_pass = 0;
  logic [6:0] q0[$], q1[$];
  always #5 clk = ~clk;
  mem_read_sequencer #(.DEPTH(4), .ROM_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .rom_addr(rom_addr0), .rom_rd(rom_rd0), .rom_data(rom_data0),
    .data_out(data_out0), .addr_out(addr_out0), .data_valid(dv0),
    .busy(busy0), .overrun(ov0));
  mem_read_sequencer #(.DEPTH(4), .ROM_LATENCY(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .rom_addr(rom_addr1), .rom_rd(rom_rd1), .rom_data(rom_data1),
    .data_out(data_out1), .addr_out(addr_out1), .data_valid(dv1),
    .busy(busy1), .overrun(ov1));
  function automatic logic [31:0] rom_word(input logic [6:0] a);
    return a == 7'd0 ? 32'hDEADBEEF : 32'h5A5A0000 | {25'b0, a};
  endfunction
  always @(posedge clk) begin
    if (rom_rd0) rom_data0 <= rom_word(rom_addr0);
    if (rom_rd1) r1a <= rom_word(rom_addr1);
    rom_data1 <= r1a;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) if (rst_n) begin
    logic [6:0] e;
    if (dv0) begin
      if (q0.size() == 0) chk("dv0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("addr_out0", addr_out0, e);
        chk("data_out0", data_out0, rom_word(e));
      end
    end
    if (dv1) begin
      if (q1.size() == 0) chk("dv1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("addr_out1", addr_out1, e);
        chk("data_out1", data_out1, rom_word(e));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [6:0] a);
    q0.push_back(a);
    q1.push_back(a);
  endtask
  task automatic do_restart();
    restart = 1;
    tick();
    restart = 0;
    repeat (2) tick();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "0"}, {rom_addr0, rom_rd0, data_out0, addr_out0, dv0, busy0, ov0}, 0);
    chk({tag, "1"}, {rom_addr1, rom_rd1, data_out1, addr_out1, dv1, busy1, ov1}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; enable = 0; restart = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    tick();
    // single fetch: rd at t0, data_valid at t0+2 (L=1) and t0+3 (L=2)
    push(0);
    enable = 1;
    #1;
    chk("rd0_t0", rom_rd0, 1);
    chk("addr0_t0", rom_addr0, 0);
    chk("rd1_t0", rom_rd1, 1);
    tick();
    enable = 0;
    chk("dv0_t1", dv0, 0);
    chk("rd0_t1", rom_rd0, 0);
    tick();
    chk("dv0_t2", dv0, 1);
    chk("dv1_t2", dv1, 0);
    chk("rom_addr0_hold", rom_addr0, 0);
    tick();
    chk("dv1_t3", dv1, 1);
    repeat (4) tick();
    // wrap over DEPTH=4
    do_restart();
    for (int i = 0; i < 5; i++) begin
      push(7'(i % 4));
      enable = 1;
      tick();
      enable = 0;
      repeat (9) tick();
    end
    // two back-to-back strobes: second is held pending
    do_restart();
    push(0); push(1);
    enable = 1;
    tick();
    tick();
    enable = 0;
    repeat (8) tick();
    chk("ov0_pair", ov0, 0);
    chk("ov1_pair", ov1, 0);
    // three strobes: third is lost
    do_restart();
    push(0); push(1);
    enable = 1;
    repeat (3) tick();
    enable = 0;
    repeat (8) tick();
    chk("ov0_triple", ov0, 1);
    chk("ov1_triple", ov1, 1);
    do_restart();
    chk("ov0_cleared", ov0, 0);
    chk("ov1_cleared", ov1, 0);
    // restart aborts an in-flight fetch
    enable = 1;
    tick();
    enable = 0;
    restart = 1;
    tick();
    restart = 0;
    repeat (6) tick();
    push(0);
    enable = 1;
    #1;
    chk("addr0_after_abort", rom_addr0, 0);
    tick();
    enable = 0;
    repeat (6) tick();
    // restart and enable together: no fetch
    restart = 1;
    enable = 1;
    #1;
    chk("rd0_restart_wins", rom_rd0, 0);
    chk("rd1_restart_wins", rom_rd1, 0);
    tick();
    restart = 0;
    enable = 0;
    repeat (5) tick();
    chk("busy0_idle", busy0, 0);
    chk("busy1_idle", busy1, 0);
    // async reset mid-WAIT
    enable = 1;
    tick();
    enable = 0;
    chk("busy1_in_wait", busy1, 1);
    #2;
    rst_n = 0;
    #1;
    chk_zero("async_reset");
    tick();
    rst_n = 1;
    repeat (6) tick();
    chk("sb0_empty", q0.size(), 0);
    chk("sb1_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
